bsg_global_buffer_row_rw: RTL and testbench

Parametrised single-row global-buffer network that carries mixed read and write requests from a west-edge port across `nodes_p` bank nodes and returns read responses in order at the east edge. It replaces the fixed write-only and read-only row networks with one block: per-request opcode, a registered hop per node, credit-based backpressure, and an output response FIFO. Bank SRAMs attach through the per-node `mem_*` ports; one instance serves one row of the buffer array.

---
 rtl/bsg_global_buffer_row_rw_if.sv | 30 +++
 rtl/bsg_global_buffer_row_rw.sv | 183 ++++++++++++++++++
 tb/tb_bsg_global_buffer_row_rw.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bsg_global_buffer_row_rw_if.sv
// Request/response bus of the global-buffer row: west-edge requests in, east-edge responses out.
// No storage; pure signal bundle.
// Requests use valid/ready, responses use valid/yumi.
interface bsg_global_buffer_row_rw_if #(
  parameter int addr_width_p = 12,
  parameter int data_width_p = 32
);
  logic                    v_i;
  logic                    w_i;
  logic [addr_width_p-1:0] addr_i;
  logic [data_width_p-1:0] data_i;
  logic                    ready_o;
  logic                    v_o;
  logic [data_width_p-1:0] data_o;
  logic                    err_o;
  logic                    w_o;
  logic                    yumi_i;

  // Client side: issues requests and consumes responses.
  modport master (
    output v_i, w_i, addr_i, data_i, yumi_i,
    input  ready_o, v_o, data_o, err_o, w_o
  );

  // Row side: accepts requests and produces responses.
  modport slave (
    input  v_i, w_i, addr_i, data_i, yumi_i,
    output ready_o, v_o, data_o, err_o, w_o
  );
endinterface

// File: rtl/bsg_global_buffer_row_rw.sv
// Single-row global-buffer network: mixed read/write requests hop across nodes_p banks, read data returns in order.
// Latency nodes_p+2 cycles from accept to v_o; one request per cycle while credits remain.
// Credit pool sized to the response FIFO; ready_o drops when no credit is left. Optional BSG_GB_ROW_WRITE_ACK_EN makes writes return acks.
module bsg_global_buffer_row_rw #(
  parameter int nodes_p           = 4,
  parameter int bank_addr_width_p = 10,
  parameter int data_width_p      = 32,
  parameter int rsp_fifo_els_p    = 4,
  localparam int id_width_lp      = (nodes_p > 1) ? $clog2(nodes_p) : 1,
  localparam int addr_width_lp    = id_width_lp + bank_addr_width_p
) (
  input  logic                                           clk_i,
  input  logic                                           reset_n_i,
  bsg_global_buffer_row_rw_if.slave                      bus,
  output logic [nodes_p-1:0]                             mem_v_o,
  output logic [nodes_p-1:0]                             mem_w_o,
  output logic [nodes_p-1:0][bank_addr_width_p-1:0]      mem_addr_o,
  output logic [nodes_p-1:0][data_width_p-1:0]           mem_data_o,
  input  logic [nodes_p-1:0][data_width_p-1:0]           mem_data_i
);

  localparam int credit_width_lp = (rsp_fifo_els_p + 1 > 1) ? $clog2(rsp_fifo_els_p + 1) : 1;
  localparam int ptr_width_lp    = (rsp_fifo_els_p > 1) ? $clog2(rsp_fifo_els_p) : 1;

  typedef struct packed {
    logic                         v;
    logic                         w;
    logic [id_width_lp-1:0]       dest;
    logic [bank_addr_width_p-1:0] addr;
    logic [data_width_p-1:0]      data;
  } req_t;

  typedef struct packed {
    logic                    v;
    logic                    hit;
    logic                    err;
`ifdef BSG_GB_ROW_WRITE_ACK_EN
    logic                    w;
`endif
    logic [data_width_p-1:0] data;
  } slot_t;

  typedef struct packed {
    logic                    err;
`ifdef BSG_GB_ROW_WRITE_ACK_EN
    logic                    w;
`endif
    logic [data_width_p-1:0] data;
  } rsp_t;

  req_t                                 stage_r [nodes_p];
  slot_t                                slot_r  [nodes_p];
  rsp_t                                 fifo_mem_r [rsp_fifo_els_p];
  logic [nodes_p-1:0][data_width_p-1:0] slot_data;
  logic [ptr_width_lp-1:0]              wptr_r, rptr_r;
  logic [credit_width_lp-1:0]           count_r, credit_r;
  logic                                 accept, produces_rsp, enq, deq;
  rsp_t                                 enq_entry, head;

  // A dest id past the last node matches no bank and comes back flagged.
  function automatic logic out_of_range(input logic [id_width_lp-1:0] dest);
    return 32'(dest) >= 32'(nodes_p);
  endfunction

  function automatic logic [ptr_width_lp-1:0] next_ptr(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(rsp_fifo_els_p - 1)) ? '0 : p + ptr_width_lp'(1);
  endfunction

  assign accept = bus.v_i & bus.ready_o;

`ifdef BSG_GB_ROW_WRITE_ACK_EN
  assign produces_rsp = 1'b1;
`else
  assign produces_rsp = ~bus.w_i;
`endif

  // Request pipeline: one registered hop per node, never stalls.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int x = 0; x < nodes_p; x++) stage_r[x] <= '0;
    end else begin
      stage_r[0].v    <= accept;
      stage_r[0].w    <= bus.w_i;
      stage_r[0].dest <= bus.addr_i[addr_width_lp-1 -: id_width_lp];
      stage_r[0].addr <= bus.addr_i[bank_addr_width_p-1:0];
      stage_r[0].data <= bus.data_i;
      for (int x = 1; x < nodes_p; x++) stage_r[x] <= stage_r[x-1];
    end
  end

  for (genvar x = 0; x < nodes_p; x++) begin : g_node
    assign mem_v_o[x]    = stage_r[x].v & (stage_r[x].dest == id_width_lp'(x));
    assign mem_w_o[x]    = stage_r[x].w;
    assign mem_addr_o[x] = stage_r[x].addr;
    assign mem_data_o[x] = stage_r[x].data;
    // Bank read data lands one cycle after the strobe, i.e. while this slot holds the request.
    assign slot_data[x]  = slot_r[x].hit ? mem_data_i[x] : slot_r[x].data;
  end

  // Response pipeline: slot x trails stage x by one cycle and picks up read data at its node.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int x = 0; x < nodes_p; x++) slot_r[x] <= '0;
    end else begin
      slot_r[0].v    <= stage_r[0].v & (~stage_r[0].w | produces_rsp_w_ack());
      slot_r[0].hit  <= mem_v_o[0] & ~mem_w_o[0];
      slot_r[0].err  <= out_of_range(stage_r[0].dest);
`ifdef BSG_GB_ROW_WRITE_ACK_EN
      slot_r[0].w    <= stage_r[0].w;
`endif
      slot_r[0].data <= '0;
      for (int x = 1; x < nodes_p; x++) begin
        slot_r[x]      <= slot_r[x-1];
        slot_r[x].hit  <= mem_v_o[x] & ~mem_w_o[x];
        slot_r[x].data <= slot_data[x-1];
      end
    end
  end

  // Whether a write travelling down the pipe owes a response.
  function automatic logic produces_rsp_w_ack();
`ifdef BSG_GB_ROW_WRITE_ACK_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  assign enq            = slot_r[nodes_p-1].v;
  assign enq_entry.err  = slot_r[nodes_p-1].err;
`ifdef BSG_GB_ROW_WRITE_ACK_EN
  assign enq_entry.w    = slot_r[nodes_p-1].w;
`endif
  assign enq_entry.data = slot_data[nodes_p-1];
  assign deq            = bus.v_o & bus.yumi_i;
  assign head           = fifo_mem_r[rptr_r];

  // Response FIFO storage; credits guarantee a free entry on every enqueue.
  always_ff @(posedge clk_i) begin
    if (enq) fifo_mem_r[wptr_r] <= enq_entry;
  end

  // Response FIFO pointers and occupancy.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (enq) wptr_r <= next_ptr(wptr_r);
      if (deq) rptr_r <= next_ptr(rptr_r);
      case ({enq, deq})
        2'b10:   count_r <= count_r + credit_width_lp'(1);
        2'b01:   count_r <= count_r - credit_width_lp'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Credit pool: one credit per response in flight or waiting in the FIFO.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      credit_r <= credit_width_lp'(rsp_fifo_els_p);
    end else begin
      case ({accept & produces_rsp, deq})
        2'b10:   credit_r <= credit_r - credit_width_lp'(1);
        2'b01:   credit_r <= credit_r + credit_width_lp'(1);
        default: credit_r <= credit_r;
      endcase
    end
  end

  assign bus.ready_o = (credit_r != '0);
  assign bus.v_o     = (count_r != '0);
  assign bus.data_o  = bus.v_o ? head.data : '0;
  assign bus.err_o   = bus.v_o & head.err;
`ifdef BSG_GB_ROW_WRITE_ACK_EN
  assign bus.w_o     = bus.v_o & head.w;
`else
  assign bus.w_o     = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_global_buffer_row_rw.sv
// Scoreboard bench for bsg_global_buffer_row_rw: a 4-node row and a 3-node row with behavioural banks.
// Expected responses are queued at request time and compared when the row hands them back.
// BSG_GB_ROW_WRITE_ACK_EN selects write-ack expectations.
module tb_bsg_global_buffer_row_rw;

`ifdef BSG_GB_ROW_WRITE_ACK_EN
  localparam bit ack_en = 1'b1;
`else
  localparam bit ack_en = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  logic yumi_en;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bsg_global_buffer_row_rw_if #(.addr_width_p(12), .data_width_p(32)) bus ();
  bsg_global_buffer_row_rw_if #(.addr_width_p(12), .data_width_p(32)) bus3 ();

  logic [3:0]        mem_v, mem_w;
  logic [3:0][9:0]   mem_addr;
  logic [3:0][31:0]  mem_wdata, mem_rdata;
  logic [2:0]        mem_v3, mem_w3;
  logic [2:0][9:0]   mem_addr3;
  logic [2:0][31:0]  mem_wdata3, mem_rdata3;

  assign bus.yumi_i  = bus.v_o & yumi_en;
  assign bus3.yumi_i = bus3.v_o & yumi_en;

  bsg_global_buffer_row_rw #(.nodes_p(4), .bank_addr_width_p(10), .data_width_p(32), .rsp_fifo_els_p(4)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .bus(bus),
    .mem_v_o(mem_v), .mem_w_o(mem_w), .mem_addr_o(mem_addr),
    .mem_data_o(mem_wdata), .mem_data_i(mem_rdata)
  );

  bsg_global_buffer_row_rw #(.nodes_p(3), .bank_addr_width_p(10), .data_width_p(32), .rsp_fifo_els_p(4)) dut3 (
    .clk_i(clk), .reset_n_i(rst_n), .bus(bus3),
    .mem_v_o(mem_v3), .mem_w_o(mem_w3), .mem_addr_o(mem_addr3),
    .mem_data_o(mem_wdata3), .mem_data_i(mem_rdata3)
  );

  function automatic logic [31:0] init_val(input int n, input int a);
    if (n == 2 && a == 'h01A) return 32'hDEADBEEF;
    return 32'h5A00_0000 ^ 32'(n << 20) ^ 32'(a * 7);
  endfunction

  // Behavioural banks: registered read, write on strobe.
  bit [31:0] bank  [4][1024];
  bit        wr_fl [4][1024];
  bit [31:0] bank3 [3][1024];
  bit        wr_fl3[3][1024];
  always @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (mem_v[n] && mem_w[n]) begin
        bank[n][mem_addr[n]]  <= mem_wdata[n];
        wr_fl[n][mem_addr[n]] <= 1'b1;
      end else if (mem_v[n]) begin
        mem_rdata[n] <= wr_fl[n][mem_addr[n]] ? bank[n][mem_addr[n]] : init_val(n, int'(mem_addr[n]));
      end
    end
    for (int n = 0; n < 3; n++) begin
      if (mem_v3[n] && mem_w3[n]) begin
        bank3[n][mem_addr3[n]]  <= mem_wdata3[n];
        wr_fl3[n][mem_addr3[n]] <= 1'b1;
      end else if (mem_v3[n]) begin
        mem_rdata3[n] <= wr_fl3[n][mem_addr3[n]] ? bank3[n][mem_addr3[n]] : init_val(n, int'(mem_addr3[n]));
      end
    end
  end

  // Reference contents as seen in request order.
  logic [31:0] ref_wr [int];
  function automatic logic [31:0] ref_rd(input int n, input int a);
    if (ref_wr.exists(n * 1024 + a)) return ref_wr[n * 1024 + a];
    return init_val(n, a);
  endfunction

  int checks = 0;
  int errors = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        w;
    int          exp_cyc;
  } exp_t;
  exp_t q[$];
  exp_t q3[$];
  exp_t mon_e, mon_e3;

  // Observers: write-strobe timing, stray strobes on the 3-node row, any v_o.
  int wr_cyc[4];
  int mv3_count = 0;
  int vo_count  = 0;
  always @(negedge clk) begin
    for (int n = 0; n < 4; n++) if (mem_v[n] && mem_w[n]) wr_cyc[n] <= cyc;
    if (mem_v3 != 3'b000) mv3_count <= mv3_count + 1;
    if (bus.v_o) vo_count <= vo_count + 1;
  end

  always @(negedge clk) begin
    if (rst_n && bus.v_o && yumi_en) begin
      if (q.size() == 0) check("rsp4_unexpected", 64'd1, 64'd0);
      else begin
        mon_e = q.pop_front();
        check("rsp4", {bus.w_o, bus.err_o, bus.data_o}, {mon_e.w, mon_e.err, mon_e.data});
        if (mon_e.exp_cyc >= 0) check("rsp4_cycle", 64'(cyc), 64'(mon_e.exp_cyc));
      end
    end
    if (rst_n && bus3.v_o && yumi_en) begin
      if (q3.size() == 0) check("rsp3_unexpected", 64'd1, 64'd0);
      else begin
        mon_e3 = q3.pop_front();
        check("rsp3", {bus3.w_o, bus3.err_o, bus3.data_o}, {mon_e3.w, mon_e3.err, mon_e3.data});
        if (mon_e3.exp_cyc >= 0) check("rsp3_cycle", 64'(cyc), 64'(mon_e3.exp_cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) assert (!(bus.yumi_i && !bus.v_o)) else $error("yumi_i without v_o");
  end

  // Drive one request (called at posedge+1); returns at posedge+1 of the cycle after accept.
  task automatic send(input bit sel, input bit wr, input int dest, input int addr,
                      input logic [31:0] d, input bit track, input bit push, output int acc);
    int          t;
    int          nodes;
    exp_t        e;
    logic [11:0] a;
    t = 0;
    nodes = sel ? 3 : 4;
    a = {dest[1:0], addr[9:0]};
    if (sel) begin
      bus3.v_i = 1'b1; bus3.w_i = wr; bus3.addr_i = a; bus3.data_i = d;
    end else begin
      bus.v_i = 1'b1; bus.w_i = wr; bus.addr_i = a; bus.data_i = d;
    end
    while (!(sel ? bus3.ready_o : bus.ready_o) && t < 100) begin
      @(posedge clk); #1; t++;
    end
    if (!(sel ? bus3.ready_o : bus.ready_o)) begin
      check("send_ready_timeout", 64'd0, 64'd1);
      bus.v_i = 1'b0; bus3.v_i = 1'b0; acc = -1;
      return;
    end
    if (push && (!wr || ack_en)) begin
      e.w    = wr;
      e.err  = (dest >= nodes);
      e.data = (wr || e.err) ? 32'h0 : (sel ? init_val(dest, addr) : ref_rd(dest, addr));
      e.exp_cyc = track ? cyc + nodes + 2 : -1;
      if (sel) q3.push_back(e); else q.push_back(e);
    end
    if (!sel && wr && dest < 4) ref_wr[dest * 1024 + addr] = d;
    @(posedge clk); #1;
    acc = cyc;
    bus.v_i = 1'b0; bus3.v_i = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q.size() != 0 || q3.size() != 0) && t < 200) begin
      @(posedge clk); #1; t++;
    end
    check("drain", 64'(q.size() + q3.size()), 64'd0);
  endtask

  task automatic wait_vo();
    int t;
    t = 0;
    while (!bus.v_o && t < 20) begin
      @(posedge clk); #1; t++;
    end
    check("wait_v_o", 64'(bus.v_o), 64'd1);
  endtask

  int acc, acc_w, acc1, acc2, vo_base;

  initial begin
    bus.v_i = 0;  bus.w_i = 0;  bus.addr_i = '0;  bus.data_i = '0;
    bus3.v_i = 0; bus3.w_i = 0; bus3.addr_i = '0; bus3.data_i = '0;
    yumi_en = 1'b1;
    rst_n = 1'b0;
    #12;
    check("rst_v_o",     64'(bus.v_o),      64'd0);
    check("rst_ready_o", 64'(bus.ready_o),  64'd1);
    check("rst_mem_v_o", 64'(mem_v),        64'd0);
    check("rst_err_o",   64'(bus.err_o),    64'd0);
    check("rst_w_o",     64'(bus.w_o),      64'd0);
    check("rst_credit",  64'(dut.credit_r), 64'd4);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single read of bank 2: strobe in cycle 3, response in cycle 6.
    send(0, 0, 2, 'h01A, 32'h0, 1, 1, acc);
    repeat (3) @(negedge clk);
    check("t1_mem_v",    64'(mem_v),       64'h4);
    check("t1_mem_addr", 64'(mem_addr[2]), 64'h01A);
    @(posedge clk); #1;
    drain();

    // Back-to-back write then two reads; reads return on consecutive cycles.
    send(0, 1, 1, 'h5, 32'h11, 1, 1, acc_w);
    send(0, 0, 1, 'h5, 32'h0,  1, 1, acc1);
    send(0, 0, 3, 'h5, 32'h0,  1, 1, acc2);
    drain();
    check("t2_wr_cycle", 64'(wr_cyc[1]), 64'(acc_w + 1));
    check("t2_credit",   64'(dut.credit_r), 64'd4);

    // Credit exhaustion with yumi held off.
    yumi_en = 1'b0;
    for (int k = 0; k < 4; k++) send(0, 0, k, 'h40 + k, 32'h0, 0, 1, acc);
    check("t3_ready_low",  64'(bus.ready_o),  64'd0);
    check("t3_credit_0",   64'(dut.credit_r), 64'd0);
    bus.v_i = 1'b1; bus.w_i = 1'b0; bus.addr_i = 12'h010;
    repeat (2) begin @(posedge clk); #1; end
    check("t3_stall_ready", 64'(bus.ready_o), 64'd0);
    bus.v_i = 1'b0;
    wait_vo();
    yumi_en = 1'b1;
    @(posedge clk); #1;
    yumi_en = 1'b0;
    check("t3_ready_back", 64'(bus.ready_o),  64'd1);
    check("t3_credit_1",   64'(dut.credit_r), 64'd1);
    send(0, 0, 0, 'h10, 32'h0, 0, 1, acc);
    check("t3_credit_5th", 64'(dut.credit_r), 64'd0);
    yumi_en = 1'b1;
    @(posedge clk); #1;
    yumi_en = 1'b0;
    yumi_en = 1'b1;
    send(0, 0, 3, 'h11, 32'h0, 0, 1, acc);
    yumi_en = 1'b0;
    check("t3_credit_hold", 64'(dut.credit_r), 64'd1);
    yumi_en = 1'b1;
    drain();
    check("t3_credit_full", 64'(dut.credit_r), 64'd4);

    // Out-of-range read on the 3-node row, then an in-range one.
    send(1, 0, 3, 'h2, 32'h0, 1, 1, acc);
    drain();
    check("t4_no_strobe", 64'(mv3_count), 64'd0);
    send(1, 0, 1, 'h7, 32'h0, 1, 1, acc);
    drain();
    check("t4_one_strobe", 64'(mv3_count), 64'd1);

    // Reset while three reads are in flight: nothing comes out.
    vo_base = vo_count;
    send(0, 0, 1, 'h20, 32'h0, 0, 0, acc);
    send(0, 0, 2, 'h21, 32'h0, 0, 0, acc);
    send(0, 0, 3, 'h22, 32'h0, 0, 0, acc);
    rst_n = 1'b0;
    #2;
    check("t5_rst_v_o",   64'(bus.v_o),     64'd0);
    check("t5_rst_mem_v", 64'(mem_v),       64'd0);
    check("t5_rst_ready", 64'(bus.ready_o), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    check("t5_v_o_never", 64'(vo_count - vo_base), 64'd0);
    check("t5_ready",     64'(bus.ready_o),  64'd1);
    check("t5_credit",    64'(dut.credit_r), 64'd4);

    // Write to {0,0x3}: acked only when write acks are enabled.
    vo_base = vo_count;
    send(0, 1, 0, 'h3, 32'h77, 1, 1, acc);
`ifdef BSG_GB_ROW_WRITE_ACK_EN
    check("t6_credit_taken", 64'(dut.credit_r), 64'd3);
    drain();
    check("t6_credit_back",  64'(dut.credit_r), 64'd4);
`else
    check("t6_credit_kept", 64'(dut.credit_r), 64'd4);
    repeat (10) begin @(posedge clk); #1; end
    check("t6_no_ack", 64'(vo_count - vo_base), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
